// File: rtl/rvfi_trace_buffer.sv
// Retirement trace buffer: tags up to NRET retired records per cycle with an order number,
// queues them in a DEPTH-entry FIFO and drops (and counts) records that do not fit.
module rvfi_trace_buffer #(
    parameter int unsigned NRET    = 1,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned REC_W   = 169,
    parameter int unsigned ORDER_W = 64
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   EN,
    input  logic [NRET-1:0]        in_valid,
    input  logic [NRET*REC_W-1:0]  in_rec,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [REC_W-1:0]       out_rec,
    output logic [ORDER_W-1:0]     out_order,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [REC_W-1:0]   rec_mem [DEPTH];
    logic [ORDER_W-1:0] tag_mem [DEPTH];

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_q, drop_d;

    logic [NRET-1:0]    v;
    logic [CW-1:0]      p;
    logic [PW-1:0]      slot [NRET];
    logic [ORDER_W-1:0] tag [NRET];
    logic [CW-1:0]      free;
    logic               push, drop, pop;
    logic [16:0]        drop_sum;

    // Compaction: each valid channel lands after all valid lower channels.
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        v   = EN ? in_valid : '0;
        for (int k = 0; k < NRET; k++) begin
            slot[k] = wr_ptr_q + acc[PW-1:0];
            tag[k]  = order_q + ORDER_W'(acc);
            acc     = acc + CW'(v[k]);
        end
        p = acc;
    end

    // Registered count only, so there is no path from out_ready to in_ready.
    assign free      = CW'(DEPTH) - count_q;
    assign in_ready  = free >= CW'(NRET);
    assign out_valid = count_q != '0;
    assign push      = in_ready && (p != '0);
    assign drop      = !in_ready && (p != '0);
    assign pop       = out_valid && out_ready;
    assign drop_sum  = {1'b0, drop_q} + 17'(p);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        order_d    = order_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(p);
        end
        if (push || drop) begin
            order_d = order_q + ORDER_W'(p);
        end
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (push ? p : '0) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            order_q    <= order_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is not reset; stale contents are masked by out_valid.
    always_ff @(posedge CLK) begin
        if (!Reset && push) begin
            for (int k = 0; k < NRET; k++) begin
                if (v[k]) begin
                    rec_mem[slot[k]] <= in_rec[k*REC_W +: REC_W];
                    tag_mem[slot[k]] <= tag[k];
                end
            end
        end
    end

    assign out_rec   = out_valid ? rec_mem[rd_ptr_q] : '0;
    assign out_order = out_valid ? tag_mem[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: two instances (NRET=1 and NRET=2, DEPTH=4) checked
// cycle by cycle against a queue-based reference model.
module tb_rvfi_trace_buffer;
    localparam int unsigned RW  = 16;
    localparam int          D1  = 4;
    localparam int          N1  = 1;
    localparam int          D2  = 4;
    localparam int          N2  = 2;

    typedef struct {
        logic [RW-1:0]   rec;
        longint unsigned tag;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          en1, v1, ordy1, irdy1, ovld1, ovf1;
    logic [RW-1:0] irec1, orec1;
    logic [7:0]    oord1;
    logic [2:0]    cnt1;
    logic [15:0]   drop1;

    logic            en2, ordy2, irdy2, ovld2, ovf2;
    logic [1:0]      v2;
    logic [2*RW-1:0] irec2;
    logic [RW-1:0]   orec2;
    logic [15:0]     oord2;
    logic [2:0]      cnt2;
    logic [15:0]     drop2;

    rvfi_trace_buffer #(.NRET(N1), .DEPTH(D1), .REC_W(RW), .ORDER_W(8)) u1 (
        .CLK(clk), .Reset(rst), .EN(en1), .in_valid(v1), .in_rec(irec1), .in_ready(irdy1),
        .out_valid(ovld1), .out_rec(orec1), .out_order(oord1), .out_ready(ordy1),
        .count(cnt1), .overflow(ovf1), .drop_cnt(drop1)
    );

    rvfi_trace_buffer #(.NRET(N2), .DEPTH(D2), .REC_W(RW), .ORDER_W(16)) u2 (
        .CLK(clk), .Reset(rst), .EN(en2), .in_valid(v2), .in_rec(irec2), .in_ready(irdy2),
        .out_valid(ovld2), .out_rec(orec2), .out_order(oord2), .out_ready(ordy2),
        .count(cnt2), .overflow(ovf2), .drop_cnt(drop2)
    );

    int checks   = 0;
    int failures = 0;

    ent_t            q1[$];
    ent_t            q2[$];
    longint unsigned ord1, ord2;
    int              m1_drop, m2_drop;
    bit              m1_ovf, m2_ovf;

    function automatic void model_reset();
        q1.delete();
        q2.delete();
        ord1 = 0; ord2 = 0;
        m1_drop = 0; m2_drop = 0;
        m1_ovf = 0; m2_ovf = 0;
    endfunction

    task automatic idle_inputs();
        rst = 0;
        en1 = 0; v1 = 0; irec1 = '0; ordy1 = 0;
        en2 = 0; v2 = '0; irec2 = '0; ordy2 = 0;
    endtask

    // Called at a negedge: compare outputs with model, drive, clock, update model.
    task automatic step1(input logic en, input logic v, input logic [RW-1:0] r,
                         input logic ordy, input logic rs);
        int            n;
        logic [RW-1:0] e_rec;
        logic [7:0]    e_ord;
        bit            fits;
        n = q1.size();
        e_rec = '0;
        e_ord = '0;
        if (n != 0) begin
            e_rec = q1[0].rec;
            e_ord = 8'(q1[0].tag);
        end
        checks += 7;
        if (ovld1 !== (n != 0)) begin failures++; $display("FAIL u1_out_valid got=%b exp=%b", ovld1, n != 0); end
        if (orec1 !== e_rec) begin failures++; $display("FAIL u1_out_rec got=%h exp=%h", orec1, e_rec); end
        if (oord1 !== e_ord) begin failures++; $display("FAIL u1_out_order got=%0d exp=%0d", oord1, e_ord); end
        if (cnt1 !== 3'(n)) begin failures++; $display("FAIL u1_count got=%0d exp=%0d", cnt1, n); end
        if (irdy1 !== ((D1 - n) >= N1)) begin failures++; $display("FAIL u1_in_ready got=%b exp=%b", irdy1, (D1 - n) >= N1); end
        if (ovf1 !== m1_ovf) begin failures++; $display("FAIL u1_overflow got=%b exp=%b", ovf1, m1_ovf); end
        if (drop1 !== 16'(m1_drop)) begin failures++; $display("FAIL u1_drop_cnt got=%0d exp=%0d", drop1, m1_drop); end
        en1 = en; v1 = v; irec1 = r; ordy1 = ordy; rst = rs;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            fits = (D1 - n) >= N1;
            if (n != 0 && ordy) void'(q1.pop_front());
            if (en && v) begin
                if (fits) q1.push_back('{rec: r, tag: ord1});
                else begin
                    m1_drop = (m1_drop >= 65535) ? 65535 : m1_drop + 1;
                    m1_ovf  = 1;
                end
                ord1 = (ord1 + 1) % 256;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic step2(input logic en, input logic [1:0] v, input logic [2*RW-1:0] r,
                         input logic ordy, input logic rs);
        int            n;
        logic [RW-1:0] e_rec;
        logic [15:0]   e_ord;
        bit            fits;
        n = q2.size();
        e_rec = '0;
        e_ord = '0;
        if (n != 0) begin
            e_rec = q2[0].rec;
            e_ord = 16'(q2[0].tag);
        end
        checks += 7;
        if (ovld2 !== (n != 0)) begin failures++; $display("FAIL u2_out_valid got=%b exp=%b", ovld2, n != 0); end
        if (orec2 !== e_rec) begin failures++; $display("FAIL u2_out_rec got=%h exp=%h", orec2, e_rec); end
        if (oord2 !== e_ord) begin failures++; $display("FAIL u2_out_order got=%0d exp=%0d", oord2, e_ord); end
        if (cnt2 !== 3'(n)) begin failures++; $display("FAIL u2_count got=%0d exp=%0d", cnt2, n); end
        if (irdy2 !== ((D2 - n) >= N2)) begin failures++; $display("FAIL u2_in_ready got=%b exp=%b", irdy2, (D2 - n) >= N2); end
        if (ovf2 !== m2_ovf) begin failures++; $display("FAIL u2_overflow got=%b exp=%b", ovf2, m2_ovf); end
        if (drop2 !== 16'(m2_drop)) begin failures++; $display("FAIL u2_drop_cnt got=%0d exp=%0d", drop2, m2_drop); end
        en2 = en; v2 = v; irec2 = r; ordy2 = ordy; rst = rs;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            fits = (D2 - n) >= N2;
            if (n != 0 && ordy) void'(q2.pop_front());
            if (en) begin
                for (int k = 0; k < N2; k++) begin
                    if (v[k]) begin
                        if (fits) q2.push_back('{rec: r[k*RW +: RW], tag: ord2});
                        else begin
                            m2_drop = (m2_drop >= 65535) ? 65535 : m2_drop + 1;
                            m2_ovf  = 1;
                        end
                        ord2 = (ord2 + 1) % 65536;
                    end
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        step1(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        checks += 10;
        if (ovld1 !== 1'b0) begin failures++; $display("FAIL reset_u1_out_valid got=%b exp=0", ovld1); end
        if (orec1 !== '0) begin failures++; $display("FAIL reset_u1_out_rec got=%h exp=0", orec1); end
        if (oord1 !== '0) begin failures++; $display("FAIL reset_u1_out_order got=%0d exp=0", oord1); end
        if (cnt1 !== '0) begin failures++; $display("FAIL reset_u1_count got=%0d exp=0", cnt1); end
        if (irdy1 !== 1'b1) begin failures++; $display("FAIL reset_u1_in_ready got=%b exp=1", irdy1); end
        if (ovf1 !== 1'b0) begin failures++; $display("FAIL reset_u1_overflow got=%b exp=0", ovf1); end
        if (drop1 !== '0) begin failures++; $display("FAIL reset_u1_drop_cnt got=%0d exp=0", drop1); end
        if (ovld2 !== 1'b0) begin failures++; $display("FAIL reset_u2_out_valid got=%b exp=0", ovld2); end
        if (irdy2 !== 1'b1) begin failures++; $display("FAIL reset_u2_in_ready got=%b exp=1", irdy2); end
        if (cnt2 !== '0) begin failures++; $display("FAIL reset_u2_count got=%0d exp=0", cnt2); end
    endtask

    task automatic test_single_order();
        logic [RW-1:0] recs [3];
        recs[0] = 16'hA0A0; recs[1] = 16'hB1B1; recs[2] = 16'hC2C2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step1(1'b1, 1'b1, recs[i], 1'b1, 1'b0);
            checks += 3;
            if (orec1 !== recs[i]) begin failures++; $display("FAIL single_rec[%0d] got=%h exp=%h", i, orec1, recs[i]); end
            if (oord1 !== 8'(i)) begin failures++; $display("FAIL single_order[%0d] got=%0d exp=%0d", i, oord1, i); end
            if (cnt1 !== 3'd1) begin failures++; $display("FAIL single_count[%0d] got=%0d exp=1", i, cnt1); end
        end
        step1(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (ovld1 !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", ovld1); end
    endtask

    task automatic test_compaction();
        logic [RW-1:0] exp_rec [3];
        exp_rec[0] = 16'h1111; exp_rec[1] = 16'h2222; exp_rec[2] = 16'h3333;
        do_reset();
        step2(1'b1, 2'b10, {exp_rec[0], 16'hDEAD}, 1'b0, 1'b0);
        step2(1'b1, 2'b11, {exp_rec[2], exp_rec[1]}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (orec2 !== exp_rec[i]) begin failures++; $display("FAIL compact_rec[%0d] got=%h exp=%h", i, orec2, exp_rec[i]); end
            if (oord2 !== 16'(i)) begin failures++; $display("FAIL compact_order[%0d] got=%0d exp=%0d", i, oord2, i); end
            step2(1'b0, 2'b00, '0, 1'b1, 1'b0);
        end
        checks++;
        if (ovld2 !== 1'b0) begin failures++; $display("FAIL compact_drained got=%b exp=0", ovld2); end
    endtask

    task automatic test_overflow();
        do_reset();
        step2(1'b1, 2'b11, {16'h0B01, 16'h0B00}, 1'b0, 1'b0);
        step2(1'b1, 2'b11, {16'h0B03, 16'h0B02}, 1'b0, 1'b0);
        checks += 2;
        if (cnt2 !== 3'd4) begin failures++; $display("FAIL ovf_full_count got=%0d exp=4", cnt2); end
        if (irdy2 !== 1'b0) begin failures++; $display("FAIL ovf_full_in_ready got=%b exp=0", irdy2); end
        step2(1'b1, 2'b11, {16'h0B05, 16'h0B04}, 1'b0, 1'b0);
        checks += 3;
        if (cnt2 !== 3'd4) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=4", cnt2); end
        if (drop2 !== 16'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop2); end
        if (ovf2 !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf2); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (oord2 !== 16'(i)) begin failures++; $display("FAIL ovf_drain_order[%0d] got=%0d exp=%0d", i, oord2, i); end
            step2(1'b0, 2'b00, '0, 1'b1, 1'b0);
        end
        step2(1'b1, 2'b01, {16'h0, 16'h0B06}, 1'b1, 1'b0);
        checks += 2;
        if (oord2 !== 16'd6) begin failures++; $display("FAIL ovf_gap_order got=%0d exp=6", oord2); end
        if (ovf2 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf2); end
    endtask

    task automatic test_wrap_concurrency();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step1(1'b1, 1'b1, 16'(16'h5000 + i), 1'b1, 1'b0);
            checks += 2;
            if (oord1 !== 8'(i)) begin failures++; $display("FAIL wrap_order[%0d] got=%0d exp=%0d", i, oord1, i); end
            if (cnt1 !== 3'd1) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, cnt1); end
        end
    endtask

    task automatic test_enable();
        step1(1'b0, 1'b1, 16'hEEEE, 1'b1, 1'b0);
        checks++;
        if (ovld1 !== 1'b0) begin failures++; $display("FAIL en_off_valid got=%b exp=0", ovld1); end
        step1(1'b1, 1'b1, 16'hEEEF, 1'b0, 1'b0);
        checks++;
        if (oord1 !== 8'd10) begin failures++; $display("FAIL en_off_order got=%0d exp=10", oord1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) step1(1'b1, 1'b1, 16'(16'h7000 + i), 1'b0, 1'b0);
        checks++;
        if (cnt1 !== 3'd3) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=3", cnt1); end
        step1(1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
        checks += 2;
        if (cnt1 !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", cnt1); end
        if (ovld1 !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", ovld1); end
        step1(1'b1, 1'b1, 16'h7123, 1'b0, 1'b0);
        checks += 2;
        if (oord1 !== 8'd0) begin failures++; $display("FAIL rmid_order got=%0d exp=0", oord1); end
        if (orec1 !== 16'h7123) begin failures++; $display("FAIL rmid_rec got=%h exp=7123", orec1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step1($urandom_range(0, 9) != 0, 1'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step2($urandom_range(0, 9) != 0, 2'($urandom), 32'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step2(1'b1, 2'b11, 32'($urandom), 1'b0, 1'b0);
        step2(1'b1, 2'b11, 32'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 32768; i++) step2(1'b1, 2'b11, 32'($urandom), 1'b0, 1'b0);
        checks += 2;
        if (drop2 !== 16'hFFFF) begin failures++; $display("FAIL sat_drop_cnt got=%h exp=ffff", drop2); end
        if (ovf2 !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%b exp=1", ovf2); end
        step2(1'b1, 2'b11, 32'($urandom), 1'b1, 1'b0);
        step2(1'b1, 2'b01, 32'($urandom), 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_order();
        test_compaction();
        test_overflow();
        test_wrap_concurrency();
        test_enable();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
